// File: rtl/fxp_alu_seq.sv
// Sequential sign-magnitude fixed-point ALU: single-pass add/sub, shift-add multiply,
// restoring divide, with saturation and divide-by-zero reporting.
module fxp_alu_seq #(
    parameter int N = 32,
    parameter int Q = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [1:0]   opcode,
    output logic [N-1:0] c,
    output logic         done_flag,
    output logic         busy,
    output logic         ovf,
    output logic         div0
);

    // state | meaning
    // IDLE  | waiting for start, c/ovf/div0 hold last result
    // CALC  | operands latched, iterating until the counter reaches terminal count

    localparam int M  = N - 1;
    localparam int PW = 2 * N - 2;
    localparam int DW = N - 1 + Q;
    localparam int CW = $clog2(N + Q + 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [M-1:0] MAX_MAG = '1;

    typedef enum logic {IDLE, CALC} state_t;

    state_t         state;
    logic [1:0]     op;
    logic           sa, sb, zb;
    logic [M-1:0]   ma, mb, rem;
    logic [PW-1:0]  acc;
    logic [DW-1:0]  dq;
    logic [CW-1:0]  cnt;

    logic           sb_eff;
    logic [N-1:0]   add_sum;
    logic [N-1:0]   div_rt;
    logic           div_ge;
    logic [M-1:0]   div_diff;
    logic           res_sign, res_ovf, res_div0;
    logic [M-1:0]   res_mag;
    logic           accept;
    logic           unused_mul_lsbs;

    // Counter is loaded with L-1; the edge that finds it at zero publishes the result.
    function automatic logic [CW-1:0] lat_m1(input logic [1:0] op_i, input logic bzero);
        case (op_i)
            OP_MUL:  return CW'(N - 1);
            OP_DIV:  return bzero ? CW'(1) : CW'(N + Q - 1);
            default: return CW'(1);
        endcase
    endfunction

    // The finishing edge may also accept a new request, so held start streams operations.
    assign accept = start && ((state == IDLE) || (cnt == '0));

    assign unused_mul_lsbs = ^acc[Q-1:0];

    always_comb begin
        sb_eff   = (op == OP_SUB) ? ~sb : sb;
        add_sum  = {1'b0, ma} + {1'b0, mb};
        div_rt   = {rem, dq[DW-1]};
        div_ge   = div_rt >= {1'b0, mb};
        div_diff = div_rt[M-1:0] - mb;
        res_sign = 1'b0;
        res_mag  = '0;
        res_ovf  = 1'b0;
        res_div0 = 1'b0;
        case (op)
            OP_MUL: begin
                res_sign = sa ^ sb;
                if (|acc[PW-1:M+Q]) begin
                    res_mag = MAX_MAG;
                    res_ovf = 1'b1;
                end else begin
                    res_mag = acc[M+Q-1:Q];
                end
            end
            OP_DIV: begin
                res_sign = sa ^ sb;
                if (zb) begin
                    res_mag  = MAX_MAG;
                    res_div0 = 1'b1;
                end else if (|dq[DW-1:M]) begin
                    res_mag = MAX_MAG;
                    res_ovf = 1'b1;
                end else begin
                    res_mag = dq[M-1:0];
                end
            end
            default: begin
                if (sa == sb_eff) begin
                    res_sign = sa;
                    if (add_sum[N-1]) begin
                        res_mag = MAX_MAG;
                        res_ovf = 1'b1;
                    end else begin
                        res_mag = add_sum[M-1:0];
                    end
                end else if (ma >= mb) begin
                    res_sign = sa;
                    res_mag  = ma - mb;
                end else begin
                    res_sign = sb_eff;
                    res_mag  = mb - ma;
                end
            end
        endcase
        if (res_mag == '0)
            res_sign = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op        <= OP_ADD;
            sa        <= 1'b0;
            sb        <= 1'b0;
            zb        <= 1'b0;
            ma        <= '0;
            mb        <= '0;
            rem       <= '0;
            acc       <= '0;
            dq        <= '0;
            cnt       <= '0;
            c         <= '0;
            done_flag <= 1'b0;
            busy      <= 1'b0;
            ovf       <= 1'b0;
            div0      <= 1'b0;
        end else begin
            done_flag <= 1'b0;
            if (state == CALC) begin
                if (cnt == '0) begin
                    c         <= {res_sign, res_mag};
                    ovf       <= res_ovf;
                    div0      <= res_div0;
                    done_flag <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end else begin
                    cnt <= cnt - 1'b1;
                    if (op == OP_MUL) begin
                        acc <= (acc << 1) + (mb[M-1] ? {{(PW-M){1'b0}}, ma} : '0);
                        mb  <= mb << 1;
                    end else if (op == OP_DIV && !zb) begin
                        if (div_ge) begin
                            rem <= div_diff;
                            dq  <= {dq[DW-2:0], 1'b1};
                        end else begin
                            rem <= div_rt[M-1:0];
                            dq  <= {dq[DW-2:0], 1'b0};
                        end
                    end
                end
            end
            if (accept) begin
                op    <= opcode;
                sa    <= a[N-1];
                sb    <= b[N-1];
                ma    <= a[M-1:0];
                mb    <= b[M-1:0];
                zb    <= (opcode == OP_DIV) && (b[M-1:0] == '0);
                acc   <= '0;
                rem   <= '0;
                dq    <= {a[M-1:0], {Q{1'b0}}};
                cnt   <= lat_m1(opcode, b[M-1:0] == '0);
                busy  <= 1'b1;
                state <= CALC;
            end
        end
    end

endmodule
